// File: rtl/butterfly_pkg.sv
// Shared types and constants for the ButterFly RV32IM core front end.
package butterfly_pkg;

  // Canonical RV32 no-op: addi x0, x0, 0.
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  // Default first fetch address after reset.
  localparam logic [31:0] BUTTERFLY_RESET_PC = 32'h0000_0000;

  // One prefetched instruction together with the address it came from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Force an address onto a word boundary; the low two bits are ignored.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/butterfly_fetch_stage_if.sv
// Bundles the instruction-memory request port, the decode-side handshake and
// the redirect inputs of the fetch stage. "master" is the fetch stage itself,
// "slave" is the surrounding core/memory/decode environment.
interface butterfly_fetch_stage_if;

  // Instruction-memory request/response.
  logic        imem_valid_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata_i;
  logic        imem_ready_i;

  // Decode handshake.
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        instr_ready_i;

  // Redirect from branch/jump/trap logic.
  logic        redirect_i;
  logic [31:0] redirect_pc_i;

  modport master (
    output imem_valid_o,
    output imem_addr_o,
    input  imem_rdata_i,
    input  imem_ready_i,
    output instr_valid_o,
    output instr_o,
    output pc_o,
    input  instr_ready_i,
    input  redirect_i,
    input  redirect_pc_i
  );

  modport slave (
    input  imem_valid_o,
    input  imem_addr_o,
    output imem_rdata_i,
    output imem_ready_i,
    input  instr_valid_o,
    input  instr_o,
    input  pc_o,
    output instr_ready_i,
    output redirect_i,
    output redirect_pc_i
  );

endinterface

// File: rtl/butterfly_fetch_fifo.sv
// Small synchronous prefetch FIFO of fetch entries. Flush empties it in one
// cycle and overrides any push or pop in the same cycle. The head entry is
// presented combinationally from storage so decode sees it the cycle after it
// was written.
module butterfly_fetch_fifo
  import butterfly_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           push_i,
  input  fetch_entry_t                   push_data_i,
  input  logic                           pop_i,
  input  logic                           flush_i,
  output logic                           full_o,
  output logic                           empty_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o,
  output fetch_entry_t                   head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  fetch_entry_t   mem_reg [DEPTH];
  logic [AW-1:0]  wr_ptr_reg;
  logic [AW-1:0]  rd_ptr_reg;
  logic [CW-1:0]  count_reg;

  logic push_en;
  logic pop_en;

  assign full_o  = (count_reg == CW'(DEPTH));
  assign empty_o = (count_reg == '0);
  assign count_o = count_reg;
  assign head_o  = mem_reg[rd_ptr_reg];

  // A pop frees a slot in the same cycle, so push is allowed when full and popping.
  assign pop_en  = pop_i && !empty_o && !flush_i;
  assign push_en = push_i && (!full_o || pop_en) && !flush_i;

  // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_en) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_en)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + CW'(push_en) - CW'(pop_en);
    end
  end

  // Entry storage; contents need no reset because occupancy gates visibility.
  always_ff @(posedge clk_i) begin
    if (push_en) mem_reg[wr_ptr_reg] <= push_data_i;
  end

endmodule

// File: rtl/butterfly_fetch_stage.sv
// Instruction-fetch front end: owns the fetch PC, issues word requests to
// instruction memory while the prefetch FIFO has room, tags returned words
// with their address and hands them to decode. A redirect flushes the FIFO and
// restarts fetch; a request already on the bus keeps its address until it is
// accepted and its data is thrown away.
module butterfly_fetch_stage
  import butterfly_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = BUTTERFLY_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  butterfly_fetch_stage_if.master  bus
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  // Request currently presented to instruction memory.
  logic        req_valid_reg, req_valid_next;
  logic [31:0] req_addr_reg,  req_addr_next;
  // Address of the next request to be issued.
  logic [31:0] pc_reg,        pc_next;
  // Set while the outstanding request belongs to a path abandoned by a redirect.
  logic        discard_reg,   discard_next;

  logic          handshake;
  logic          req_stalled;
  logic          push;
  logic          pop;
  logic [CW-1:0] count_after;

  fetch_entry_t  push_entry;
  fetch_entry_t  head_entry;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  assign handshake   = req_valid_reg && bus.imem_ready_i;
  assign req_stalled = req_valid_reg && !bus.imem_ready_i;
  // Stale data and data arriving alongside a redirect never reach the FIFO.
  assign push        = handshake && !discard_reg && !bus.redirect_i && !fifo_full;
  assign pop         = bus.instr_valid_o && bus.instr_ready_i;

  assign push_entry.pc    = req_addr_reg;
  assign push_entry.instr = bus.imem_rdata_i;

  butterfly_fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .flush_i     (bus.redirect_i),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count),
    .head_o      (head_entry)
  );

  // FIFO occupancy as it will be after this edge; decides whether a new request may issue.
  always_comb begin
    count_after = fifo_count;
    if (bus.redirect_i) begin
      count_after = '0;
    end else begin
      count_after = fifo_count + CW'(push) - CW'(pop);
    end
  end

  // Next fetch PC, discard flag and request; a stalled request is never altered.
  always_comb begin
    pc_next        = pc_reg;
    discard_next   = discard_reg;
    req_valid_next = req_valid_reg;
    req_addr_next  = req_addr_reg;

    if (bus.redirect_i) begin
      pc_next = word_align(bus.redirect_pc_i);
    end else if (handshake && !discard_reg) begin
      pc_next = pc_reg + 32'd4;
    end

    if (req_stalled && bus.redirect_i) begin
      discard_next = 1'b1;
    end else if (handshake) begin
      discard_next = 1'b0;
    end

    if (!req_stalled) begin
      req_valid_next = (count_after < CW'(FIFO_DEPTH));
      req_addr_next  = pc_next;
    end
  end

  // Fetch control state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_valid_reg <= 1'b0;
      req_addr_reg  <= word_align(RESET_PC);
      pc_reg        <= word_align(RESET_PC);
      discard_reg   <= 1'b0;
    end else begin
      req_valid_reg <= req_valid_next;
      req_addr_reg  <= req_addr_next;
      pc_reg        <= pc_next;
      discard_reg   <= discard_next;
    end
  end

  assign bus.imem_valid_o  = req_valid_reg;
  assign bus.imem_addr_o   = req_addr_reg;
  assign bus.instr_valid_o = !fifo_empty;
  assign bus.instr_o       = fifo_empty ? INSTR_NOP : head_entry.instr;
  assign bus.pc_o          = fifo_empty ? 32'h0000_0000 : head_entry.pc;

endmodule

// File: tb/tb_butterfly_fetch_stage.sv
// Bench for the fetch stage: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a transaction-level
// model (a queue of fetched words plus the outstanding request).
module tb_butterfly_fetch_stage;
  import butterfly_pkg::*;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0;
  logic rst1;

  butterfly_fetch_stage_if bus0 ();
  butterfly_fetch_stage_if bus1 ();

  butterfly_fetch_stage #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (DEPTH)
  ) dut0 (
    .clk_i (clk),
    .rst_i (rst0),
    .bus   (bus0)
  );

  butterfly_fetch_stage #(
    .RESET_PC   (32'hFFFF_FFF8),
    .FIFO_DEPTH (DEPTH)
  ) dut1 (
    .clk_i (clk),
    .rst_i (rst1),
    .bus   (bus1)
  );

  int checks = 0;
  int errors = 0;
  bit verbose = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------
  // Reference model for dut0: the fetch contract in transaction terms.
  // ---------------------------------------------------------------
  bit           model_live = 1'b0;
  bit           m_valid;
  logic [31:0]  m_addr;
  logic [31:0]  m_pc;
  bit           m_disc;
  fetch_entry_t mq[$];

  always @(posedge clk) begin
    bit           hs;
    bit           was_disc;
    fetch_entry_t e;
    if (rst0) begin
      m_valid    = 1'b0;
      m_addr     = 32'h0;
      m_pc       = 32'h0;
      m_disc     = 1'b0;
      mq.delete();
      model_live = 1'b1;
    end else if (model_live) begin
      hs       = m_valid && bus0.imem_ready_i;
      was_disc = m_disc;
      if (bus0.redirect_i) begin
        mq.delete();
      end else begin
        if (mq.size() > 0 && bus0.instr_ready_i) void'(mq.pop_front());
        if (hs && !was_disc) begin
          e.pc    = m_addr;
          e.instr = bus0.imem_rdata_i;
          mq.push_back(e);
        end
      end
      if (bus0.redirect_i && m_valid && !bus0.imem_ready_i) m_disc = 1'b1;
      else if (hs) m_disc = 1'b0;
      if (bus0.redirect_i) m_pc = bus0.redirect_pc_i & 32'hFFFF_FFFC;
      else if (hs && !was_disc) m_pc = m_pc + 32'd4;
      if (!(m_valid && !bus0.imem_ready_i)) begin
        m_valid = (mq.size() < DEPTH);
        m_addr  = m_pc;
      end
    end
  end

  // Per-cycle comparison of dut0 against the model.
  always @(negedge clk) begin
    if (model_live) begin
      check("imem_valid", 32'(bus0.imem_valid_o), 32'(m_valid));
      if (m_valid) check("imem_addr", bus0.imem_addr_o, m_addr);
      check("instr_valid", 32'(bus0.instr_valid_o), 32'(mq.size() > 0));
      check("instr", bus0.instr_o, (mq.size() > 0) ? mq[0].instr : INSTR_NOP);
      check("pc", bus0.pc_o, (mq.size() > 0) ? mq[0].pc : 32'h0);
    end
  end

  // One line per decode transfer during the directed phase.
  always @(posedge clk) begin
    if (verbose && !rst0 && bus0.instr_valid_o && bus0.instr_ready_i && !bus0.redirect_i)
      $display("decode pc=%h instr=%h", bus0.pc_o, bus0.instr_o);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
    bus0.imem_rdata_i = $urandom;
    bus1.imem_rdata_i = $urandom;
  endtask

  // Run dut0 until it presents a request at the given address (bounded).
  task automatic wait_addr(input logic [31:0] a);
    int n = 0;
    while (!(bus0.imem_valid_o && bus0.imem_addr_o == a) && n < 64) begin
      step();
      n++;
    end
    check("wait_addr", bus0.imem_addr_o, a);
  endtask

  initial begin
    rst0 = 1'b1;
    rst1 = 1'b1;
    bus0.imem_ready_i  = 1'b1;
    bus0.instr_ready_i = 1'b1;
    bus0.redirect_i    = 1'b0;
    bus0.redirect_pc_i = 32'h0;
    bus0.imem_rdata_i  = $urandom;
    bus1.imem_ready_i  = 1'b1;
    bus1.instr_ready_i = 1'b1;
    bus1.redirect_i    = 1'b0;
    bus1.redirect_pc_i = 32'h0;
    bus1.imem_rdata_i  = $urandom;

    // Reset state.
    step(); step();
    check("rst_imem_valid", 32'(bus0.imem_valid_o), 32'd0);
    check("rst_imem_addr", bus0.imem_addr_o, 32'h0);
    check("rst_instr_valid", 32'(bus0.instr_valid_o), 32'd0);
    check("rst_instr", bus0.instr_o, 32'h0000_0013);
    check("rst_pc", bus0.pc_o, 32'h0);

    // Streaming: 0, 4, 8 with one cycle memory-to-decode latency.
    rst0 = 1'b0;
    step();
    check("s_valid0", 32'(bus0.imem_valid_o), 32'd1);
    check("s_addr0", bus0.imem_addr_o, 32'h0);
    step();
    check("s_addr4", bus0.imem_addr_o, 32'h4);
    check("s_ivalid", 32'(bus0.instr_valid_o), 32'd1);
    check("s_pc0", bus0.pc_o, 32'h0);
    step();
    check("s_addr8", bus0.imem_addr_o, 32'h8);
    check("s_pc4", bus0.pc_o, 32'h4);

    // Decode stall fills the FIFO after exactly two handshakes.
    rst0 = 1'b1; step(); rst0 = 1'b0;
    bus0.instr_ready_i = 1'b0;
    step(); step(); step();
    check("stall_valid", 32'(bus0.imem_valid_o), 32'd0);
    check("stall_pc", bus0.pc_o, 32'h0);
    step();
    check("stall_valid2", 32'(bus0.imem_valid_o), 32'd0);
    check("stall_pc2", bus0.pc_o, 32'h0);
    bus0.instr_ready_i = 1'b1;
    step();
    check("resume_addr", bus0.imem_addr_o, 32'h8);
    check("resume_pc", bus0.pc_o, 32'h4);

    // Memory not ready for three cycles holds the request.
    wait_addr(32'h10);
    bus0.imem_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_valid", 32'(bus0.imem_valid_o), 32'd1);
      check("hold_addr", bus0.imem_addr_o, 32'h10);
    end
    bus0.imem_ready_i = 1'b1;
    step();
    check("hold_next", bus0.imem_addr_o, 32'h14);

    // Redirect while a request is pending: stale data discarded.
    wait_addr(32'h20);
    bus0.imem_ready_i  = 1'b0;
    bus0.redirect_i    = 1'b1;
    bus0.redirect_pc_i = 32'h100;
    step();
    bus0.redirect_i = 1'b0;
    check("rdp_addr", bus0.imem_addr_o, 32'h20);
    check("rdp_ivalid", 32'(bus0.instr_valid_o), 32'd0);
    step();
    check("rdp_addr2", bus0.imem_addr_o, 32'h20);
    bus0.imem_ready_i = 1'b1;
    step();
    check("rdp_new", bus0.imem_addr_o, 32'h100);
    check("rdp_empty", 32'(bus0.instr_valid_o), 32'd0);
    step();
    check("rdp_pc", bus0.pc_o, 32'h100);

    // Redirect coinciding with a handshake and a pop; unaligned target.
    bus0.redirect_i    = 1'b1;
    bus0.redirect_pc_i = 32'h38;
    step();
    bus0.redirect_i = 1'b0;
    wait_addr(32'h40);
    check("rdh_pre_ivalid", 32'(bus0.instr_valid_o), 32'd1);
    bus0.redirect_i    = 1'b1;
    bus0.redirect_pc_i = 32'h203;
    step();
    bus0.redirect_i = 1'b0;
    check("rdh_empty", 32'(bus0.instr_valid_o), 32'd0);
    check("rdh_addr", bus0.imem_addr_o, 32'h200);
    step();
    check("rdh_pc", bus0.pc_o, 32'h200);

    // Non-zero reset PC with wrap, then reset during a stalled request.
    rst1 = 1'b0;
    step();
    check("w_addr0", bus1.imem_addr_o, 32'hFFFF_FFF8);
    check("w_valid0", 32'(bus1.imem_valid_o), 32'd1);
    step();
    check("w_addr1", bus1.imem_addr_o, 32'hFFFF_FFFC);
    check("w_pc0", bus1.pc_o, 32'hFFFF_FFF8);
    step();
    check("w_addr2", bus1.imem_addr_o, 32'h0000_0000);
    check("w_pc1", bus1.pc_o, 32'hFFFF_FFFC);
    bus1.imem_ready_i = 1'b0;
    step();
    check("w_hold", bus1.imem_addr_o, 32'h0000_0000);
    rst1 = 1'b1;
    step();
    check("w_rst_valid", 32'(bus1.imem_valid_o), 32'd0);
    check("w_rst_addr", bus1.imem_addr_o, 32'hFFFF_FFF8);
    check("w_rst_ivalid", 32'(bus1.instr_valid_o), 32'd0);
    rst1 = 1'b0;
    bus1.imem_ready_i = 1'b1;
    step();
    check("w_restart_valid", 32'(bus1.imem_valid_o), 32'd1);
    check("w_restart_addr", bus1.imem_addr_o, 32'hFFFF_FFF8);

    // Randomized traffic against the model.
    verbose = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rst0               = ($urandom_range(0, 199) == 0);
      bus0.imem_ready_i  = ($urandom_range(0, 9) < 7);
      bus0.instr_ready_i = ($urandom_range(0, 9) < 6);
      bus0.redirect_i    = ($urandom_range(0, 19) == 0);
      bus0.redirect_pc_i = $urandom;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/butterfly_fetch_stage.md
Name: butterfly_fetch_stage

Overview:
- Instruction-fetch front end of the ButterFly RV32IM core. It owns the PC and drives the core's instruction-memory valid/ready port.
- Fetched words go into a small prefetch FIFO. The FIFO feeds decode through a valid/ready handshake, each word tagged with its PC.
- Redirects from branch/jump/trap logic flush the FIFO and restart fetch at the new PC.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 2, prefetch entries; power of two, legal range 2..8.

Ports:
- clk_i  in  1  core clock, rising edge.
- rst_i  in  1  synchronous, active-high reset.
- imem_valid_o  out  1  fetch request valid.
- imem_addr_o  out  32  fetch address, word aligned.
- imem_rdata_i  in  32  instruction word; valid in the cycle imem_valid_o && imem_ready_i.
- imem_ready_i  in  1  memory accepts the request and returns data in the same cycle.
- instr_valid_o  out  1  FIFO head valid to decode.
- instr_o  out  32  instruction at FIFO head.
- pc_o  out  32  PC of instr_o.
- instr_ready_i  in  1  decode consumes the head when instr_valid_o && instr_ready_i.
- redirect_i  in  1  flush and restart fetch.
- redirect_pc_i  in  32  new fetch PC; bits [1:0] ignored, treated as zero.

Behaviour:
- Reset (rst_i high at a clock edge):
  - imem_valid_o=0, imem_addr_o=RESET_PC, instr_valid_o=0, instr_o=32'h0000_0013 (NOP), pc_o=0.
  - FIFO empty, discard flag clear, fetch PC = RESET_PC.
  - Reset asserted mid-transaction drops the request immediately; no stability obligation survives reset.
- Request issue:
  - imem_valid_o rises when FIFO count < FIFO_DEPTH. In the first cycle after reset it is high with imem_addr_o=RESET_PC.
  - Once raised, imem_valid_o and imem_addr_o hold stable until imem_ready_i. This holds across redirects.
- Handshake cycle (valid && ready):
  - Entry {imem_addr_o, imem_rdata_i} pushes into the FIFO unless the discard flag is set or redirect_i is high that cycle.
  - Fetch PC advances by 4; 32-bit wrap, 32'hFFFF_FFFC+4 = 0.
  - A new request may issue the next cycle.
- Back-to-back fetch: at most one handshake per cycle, so throughput is 1 instruction/cycle when imem_ready_i stays high and decode drains.
- Latency: a word accepted in cycle N is visible at instr_valid_o in cycle N+1. There is no memory-to-decode bypass.
- FIFO:
  - Simultaneous push and pop are allowed; count is unchanged.
  - When full, no new request issues, but a request already pending stays asserted. It cannot overflow, because issue only happens below full and count never grows without a handshake.
  - When empty, instr_valid_o=0, instr_o=NOP, pc_o=0.
- Redirect (redirect_i high at an edge):
  - FIFO flushed; a pop in that cycle is ignored, redirect wins.
  - Fetch PC := {redirect_pc_i[31:2],2'b00}.
  - If a request is pending without ready: the discard flag is set, the request keeps its old address until accepted, its data is dropped, the flag clears, and the next request uses the new PC.
  - If ready coincides with redirect: the data is dropped, the flag is not set, and the new PC is requested the next cycle.
  - If no request is pending: the new PC is requested the next cycle.
  - Back-to-back redirects: the last one wins. The discard flag stays set until the stale handshake completes.
- Decode stall: instr_valid_o/instr_o/pc_o hold stable while instr_ready_i=0 and no redirect occurs.

Decomposition:
- butterfly_pkg gains:
  - INSTR_NOP = 32'h0000_0013.
  - BUTTERFLY_RESET_PC (default source for RESET_PC).
  - typedef fetch_entry_t {logic [31:0] pc; logic [31:0] instr;}.
- Sub-module butterfly_fetch_fifo:
  - Synchronous FIFO of fetch_entry_t, parameter DEPTH.
  - Ports: push/pop/flush, full/empty, head.
  - Single-cycle flush; flush has priority over push and pop.
- The top level holds the PC, request/hold logic and discard flag.

Test Plan:
- Reset release, imem_ready_i=1, instr_ready_i=1 -> imem_addr_o sequence 0,4,8,...; instr_valid_o first high one cycle after the first handshake with pc_o=0; one instruction per cycle thereafter.
- Decode stalled (instr_ready_i=0), memory always ready, FIFO_DEPTH=2 -> exactly 2 handshakes (PC 0,4), then imem_valid_o=0; head stays pc_o=0. Release stall -> fetch resumes at 8.
- imem_ready_i low for 3 cycles with a request at 0x10 -> imem_addr_o held at 0x10 all 3 cycles; entry pushed only on the ready cycle.
- Request at 0x20 pending, redirect_i with redirect_pc_i=0x100 -> addr stays 0x20 until ready, data discarded (never seen at decode); next request 0x100; first decode pc_o=0x100.
- redirect_i coinciding with a handshake at 0x40 and a decode pop, redirect_pc_i=0x203 -> FIFO empty next cycle; 0x40 data dropped; next request addr 0x200.
- RESET_PC=32'hFFFF_FFF8 -> fetch 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000. Assert rst_i during a stalled request -> imem_valid_o=0 next cycle, then restart at RESET_PC.
